// File: rtl/fibonacci_seq_if.sv
// Output stream of the Fibonacci sequence generator: one term per valid/ready transfer.
interface fibonacci_seq_if #(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 16
);
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_value;
  logic [IDX_WIDTH-1:0] out_index;

  modport master (output out_valid, output out_value, output out_index, input out_ready);
  modport slave  (input out_valid, input out_value, input out_index, output out_ready);
endinterface

// File: rtl/fibonacci_seq.sv
// Fibonacci-type sequence generator: programmable seeds and term count, start/abort control,
// valid/ready output stream and overflow detection with wrap or stop policy.
module fibonacci_seq #(
  parameter int WIDTH       = 16,
  parameter int IDX_WIDTH   = 16,
  parameter int STOP_ON_OVF = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     seed0,
  input  logic [WIDTH-1:0]     seed1,
  input  logic [IDX_WIDTH-1:0] count,
  fibonacci_seq_if.master      stream,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [WIDTH-1:0]     first, next;
  logic [IDX_WIDTH-1:0] index, len;
  logic                 nvalid;
  logic [WIDTH:0]       sum;
  logic                 xfer, accept, last_term, end_run;

  assign sum       = {1'b0, first} + {1'b0, next};
  assign xfer      = (state == RUN) && stream.out_ready;
  assign accept    = (state != RUN) && start && !abort;
  assign last_term = (index == len - IDX_WIDTH'(1));
  // Term-count limit takes priority; the overflow stop only matters in stop mode.
  assign end_run   = last_term || ((STOP_ON_OVF != 0) && !nvalid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    case (state)
      IDLE, DONE: if (accept) state_d = (count == '0) ? DONE : RUN;
      RUN:        if (xfer && end_run) state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first    <= '0;
      next     <= '0;
      index    <= '0;
      len      <= '0;
      nvalid   <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      first    <= seed0;
      next     <= seed1;
      index    <= '0;
      len      <= count;
      nvalid   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (xfer) begin
        if (sum[WIDTH]) begin
          nvalid   <= 1'b0;
          overflow <= 1'b1;
        end
        // The final term stays on the outputs in DONE, so the window only advances mid-run
        // (or when an abort swallows the in-flight term).
        if (!end_run || abort) begin
          first <= next;
          next  <= sum[WIDTH-1:0];
          index <= index + IDX_WIDTH'(1);
        end
      end
      // NOTE: non-blocking updates resolve last-assignment-wins, so abort's clear beats a
      // same-cycle overflow set.
      if (abort) overflow <= 1'b0;
    end
  end

  assign stream.out_valid = (state == RUN);
  assign stream.out_value = first;
  assign stream.out_index = index;
  assign busy             = (state == RUN);
  assign done             = (state == DONE);

endmodule

// File: tb/tb_fibonacci_seq.sv
// Self-checking bench for fibonacci_seq: one stop-mode and one wrap-mode instance, table vectors,
// hand-written corner sequences and randomized runs against a term-list reference model.
module tb_fibonacci_seq;
  localparam int W  = 16;
  localparam int IW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]     start = '0, abort = '0, ready = '0;
  logic [W-1:0]   seed0 = '0, seed1 = '0;
  logic [IW-1:0]  count = '0;
  logic [1:0]     busy_o, done_o, ovf_o, valid_o;
  logic [1:0][W-1:0]  value_o;
  logic [1:0][IW-1:0] index_o;

  fibonacci_seq_if #(.WIDTH(W), .IDX_WIDTH(IW)) s0_if ();
  fibonacci_seq_if #(.WIDTH(W), .IDX_WIDTH(IW)) s1_if ();

  fibonacci_seq #(.WIDTH(W), .IDX_WIDTH(IW), .STOP_ON_OVF(1)) dut_stop (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
    .seed0(seed0), .seed1(seed1), .count(count), .stream(s0_if.master),
    .busy(busy_o[0]), .done(done_o[0]), .overflow(ovf_o[0])
  );

  fibonacci_seq #(.WIDTH(W), .IDX_WIDTH(IW), .STOP_ON_OVF(0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
    .seed0(seed0), .seed1(seed1), .count(count), .stream(s1_if.master),
    .busy(busy_o[1]), .done(done_o[1]), .overflow(ovf_o[1])
  );

  assign s0_if.out_ready = ready[0];
  assign s1_if.out_ready = ready[1];
  assign valid_o[0] = s0_if.out_valid;
  assign valid_o[1] = s1_if.out_valid;
  assign value_o[0] = s0_if.out_value;
  assign value_o[1] = s1_if.out_value;
  assign index_o[0] = s0_if.out_index;
  assign index_o[1] = s1_if.out_index;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  // Reference model: the term list with wrapped values and a "true value too big" flag per term.
  logic [W-1:0] mval [0:255];
  bit           mbig [0:255];
  int           mn;

  task automatic build_model(input logic [W-1:0] s0, input logic [W-1:0] s1, input int cnt,
                             input bit stop);
    int unsigned full;
    mval[0] = s0; mval[1] = s1; mbig[0] = 1'b0; mbig[1] = 1'b0;
    for (int k = 2; k <= cnt + 1 && k < 256; k++) begin
      full    = int'(mval[k-2]) + int'(mval[k-1]);
      mval[k] = W'(full);
      mbig[k] = mbig[k-2] | mbig[k-1] | (full >= (32'd1 << W));
    end
    mn = cnt;
    if (stop)
      for (int i = 0; i < cnt; i++)
        if (mbig[i]) begin mn = i; break; end
  endtask

  function automatic bit model_ovf(input int upto);
    bit r = 1'b0;
    for (int k = 2; k <= upto; k++) r |= mbig[k];
    return r;
  endfunction

  typedef struct {
    logic [W-1:0] s0, s1;
    int           cnt;
    int           dut;      // 0 = stop-on-overflow, 1 = wrap
    bit           rnd;      // random backpressure
    int           exp_n;    // -1: model only
    bit           exp_ovf;
    bit           chk_last;
    logic [W-1:0] exp_last;
  } vec_t;

  vec_t tbl [7];

  task automatic run_vec(input vec_t v, input string tag);
    int d, k, cyc, budget;
    bit done_seen;
    d = v.dut;
    build_model(v.s0, v.s1, v.cnt, d == 0);
    @(negedge clk);
    seed0 = v.s0; seed1 = v.s1; count = IW'(v.cnt); start[d] = 1'b1; ready[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    k = 0; cyc = 0; done_seen = 1'b0; budget = 4 * v.cnt + 20;
    while (cyc < budget) begin
      if (done_o[d]) begin done_seen = 1'b1; break; end
      check($sformatf("%s valid c=%0d", tag, cyc), valid_o[d], 1);
      check($sformatf("%s busy c=%0d", tag, cyc), busy_o[d], 1);
      if (k < mn) begin
        check($sformatf("%s value k=%0d", tag, k), value_o[d], mval[k]);
        check($sformatf("%s index k=%0d", tag, k), index_o[d], k);
        check($sformatf("%s ovf k=%0d", tag, k), ovf_o[d], model_ovf(k + 1));
      end else begin
        fail($sformatf("%s extra_term k=%0d", tag, k));
      end
      ready[d] = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid_o[d] && ready[d]) k++;
      @(negedge clk);
      cyc++;
    end
    if (!done_seen) begin
      fail($sformatf("%s done_timeout", tag));
    end else begin
      if (!v.rnd) check($sformatf("%s done_latency", tag), cyc, mn);
      check($sformatf("%s term_count", tag), k, mn);
      check($sformatf("%s done_valid", tag), valid_o[d], 0);
      check($sformatf("%s done_busy", tag), busy_o[d], 0);
      check($sformatf("%s done_ovf", tag), ovf_o[d], model_ovf(mn + 1));
      if (mn > 0) begin
        check($sformatf("%s held_value", tag), value_o[d], mval[mn-1]);
        check($sformatf("%s held_index", tag), index_o[d], mn - 1);
      end
      if (v.exp_n >= 0) begin
        check($sformatf("%s tbl_terms", tag), k, v.exp_n);
        check($sformatf("%s tbl_ovf", tag), ovf_o[d], v.exp_ovf);
        if (v.chk_last) check($sformatf("%s tbl_last", tag), value_o[d], v.exp_last);
      end
    end
  endtask

  initial begin
    int k, cyc, stall;
    bit stalled;
    vec_t rv;

    //         s0        s1        cnt  dut rnd exp_n ovf chk last
    tbl[0] = '{16'd0,    16'd1,    10,  0,  0,  10,   0,  1,  16'd34};
    tbl[1] = '{16'd0,    16'd1,    100, 0,  0,  25,   1,  1,  16'd46368};
    tbl[2] = '{16'd0,    16'd1,    100, 1,  0,  100,  1,  0,  16'd0};
    tbl[3] = '{16'd5,    16'd7,    3,   0,  0,  3,    0,  1,  16'd12};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 5,   0,  0,  2,    1,  1,  16'hFFFF};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 5,   1,  0,  5,    1,  1,  16'd65531};
    tbl[6] = '{16'd0,    16'd1,    10,  1,  1,  10,   0,  1,  16'd34};

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset valid d=%0d", d), valid_o[d], 0);
      check($sformatf("reset busy d=%0d", d), busy_o[d], 0);
      check($sformatf("reset done d=%0d", d), done_o[d], 0);
      check($sformatf("reset ovf d=%0d", d), ovf_o[d], 0);
      check($sformatf("reset value d=%0d", d), value_o[d], 0);
      check($sformatf("reset index d=%0d", d), index_o[d], 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // count = 0: done next cycle, no term.
    rv = '{16'd3, 16'd4, 0, 0, 0, 0, 0, 0, 16'd0};
    run_vec(rv, "cnt0");

    // Backpressure at index 4, with a start pulse during the stall that must be ignored.
    build_model(16'd0, 16'd1, 10, 1'b1);
    @(negedge clk);
    seed0 = 16'd0; seed1 = 16'd1; count = 16'd10; start[0] = 1'b1; ready[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    k = 0; cyc = 0; stall = 0; stalled = 1'b0;
    while (!done_o[0] && cyc < 60) begin
      if (valid_o[0] && k < 10) begin
        check($sformatf("bp value k=%0d", k), value_o[0], mval[k]);
        check($sformatf("bp index k=%0d", k), index_o[0], k);
      end
      if (stalled && k == 4) check("bp hold_value", value_o[0], 16'd3);
      start[0] = 1'b0;
      if (k == 4 && !stalled) begin stalled = 1'b1; stall = 3; end
      if (stall > 0) begin
        ready[0] = 1'b0;
        stall--;
        if (stall == 2) begin start[0] = 1'b1; seed0 = 16'd9; seed1 = 16'd9; count = 16'd2; end
      end else begin
        ready[0] = 1'b1;
      end
      if (valid_o[0] && ready[0]) k++;
      @(negedge clk);
      cyc++;
    end
    start[0] = 1'b0;
    check("bp done", done_o[0], 1);
    check("bp terms", k, 10);
    check("bp cycles", cyc, 13);
    check("bp last", value_o[0], 16'd34);

    // Abort at index 6 on the wrap instance with overflow already set.
    build_model(16'hFFFF, 16'hFFFF, 10, 1'b0);
    @(negedge clk);
    seed0 = 16'hFFFF; seed1 = 16'hFFFF; count = 16'd10; start[1] = 1'b1; ready[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    cyc = 0;
    while (!(valid_o[1] && index_o[1] == 16'd6) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 30) begin
      fail("abort reach_index6");
    end else begin
      check("abort pre_value", value_o[1], mval[6]);
      check("abort pre_ovf", ovf_o[1], model_ovf(7));
      abort[1] = 1'b1;
      @(negedge clk);
      abort[1] = 1'b0;
      check("abort valid", valid_o[1], 0);
      check("abort done", done_o[1], 0);
      check("abort busy", busy_o[1], 0);
      check("abort ovf", ovf_o[1], 0);
      @(negedge clk);
      check("abort stays_idle", valid_o[1], 0);
    end
    run_vec(tbl[6], "after_abort");

    // start and abort together: abort wins (instance 0 sits in DONE here).
    @(negedge clk);
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    check("start_abort valid", valid_o[0], 0);
    check("start_abort busy", busy_o[0], 0);
    check("start_abort done", done_o[0], 0);
    @(negedge clk);
    check("start_abort idle", valid_o[0], 0);

    for (int r = 0; r < 8; r++) begin
      rv.s0 = W'($urandom); rv.s1 = W'($urandom);
      if (r < 3) begin rv.s0 = W'($urandom_range(0, 20)); rv.s1 = W'($urandom_range(0, 20)); end
      rv.cnt = $urandom_range(0, 40); rv.dut = $urandom_range(0, 1); rv.rnd = 1'b1;
      rv.exp_n = -1; rv.exp_ovf = 1'b0; rv.chk_last = 1'b0; rv.exp_last = '0;
      run_vec(rv, $sformatf("rnd%0d", r));
    end

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    seed0 = 16'd0; seed1 = 16'd1; count = 16'd20; start[0] = 1'b1; ready[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cyc = 0;
    while (!(valid_o[0] && index_o[0] == 16'd5) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 30) fail("rst reach_index5");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst valid", valid_o[0], 0);
    check("rst busy", busy_o[0], 0);
    check("rst done", done_o[0], 0);
    check("rst ovf", ovf_o[0], 0);
    check("rst value", value_o[0], 0);
    check("rst index", index_o[0], 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst no_restart", valid_o[0], 0);
    check("rst idle_busy", busy_o[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fibonacci_seq.md
Name: fibonacci_seq

Overview:
Parametrised Fibonacci-type sequence generator, the next generation of the free-running 16-bit Fibonacci counter. Adds:
- configurable width and seeds
- a programmable term count
- a start/abort control FSM
- a valid/ready output stream with backpressure
- overflow detection with a selectable wrap or stop policy

It is used as a synthesis example and a stimulus source for downstream arithmetic blocks.

Parameters:
WIDTH, 16, bit width of sequence values (min 2).
IDX_WIDTH, 16, width of the term index and the term count.
STOP_ON_OVF, 1, 1 = end the run after the last representable term; 0 = wrap modulo 2^WIDTH and continue.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  begin a new run; sampled in IDLE or DONE only.
abort  in  1  terminate the current run; return to IDLE.
seed0  in  WIDTH  term 0 value, latched on accepted start.
seed1  in  WIDTH  term 1 value, latched on accepted start.
count  in  IDX_WIDTH  number of terms to emit, latched on accepted start.
out_valid  out  1  out_value/out_index hold a term.
out_ready  in  1  consumer accepts the term.
out_value  out  WIDTH  current term.
out_index  out  IDX_WIDTH  index of the current term, 0-based.
busy  out  1  high in RUN.
done  out  1  high in DONE.
overflow  out  1  sticky: a computed term exceeded 2^WIDTH-1 during this run.

Behaviour:
- Reset (async): state=IDLE. All of the following are 0: out_valid, busy, done, overflow, out_value, out_index, internal first/next/nvalid/len.
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE with start=1 and abort=0:
  - latch first=seed0, next=seed1, len=count, index=0, nvalid=1; clear overflow and done.
  - If count==0, go to DONE; no term is emitted.
  - Otherwise go to RUN; out_valid=1 in the next cycle (1-cycle latency from start).
- RUN outputs: out_valid=1, busy=1, out_value=first, out_index=index.
- Transfer = out_valid & out_ready. With out_ready=0, all outputs are held stable and no state advances.
- On each transfer:
  - sum = first + next, computed at WIDTH+1 bits.
  - first <= next; next <= sum[WIDTH-1:0]; index <= index+1.
  - If sum[WIDTH]==1: nvalid <= 0 and overflow <= 1.
- End-of-run checks on a transfer, in priority order:
  1. index==len-1 → DONE.
  2. Else if STOP_ON_OVF=1 and nvalid==0 → DONE. The emitted term was the last representable one; overflow is already 1.
  3. Else stay in RUN.
- STOP_ON_OVF=0: values wrap modulo 2^WIDTH, overflow stays sticky, and nvalid is ignored.
- DONE: out_valid=0, busy=0, done=1. The last emitted value and index are held on out_value/out_index. Overflow is held.
- Abort (any state, no start effect): next cycle state=IDLE, out_valid=0, done=0. Overflow is cleared. An in-flight term with out_ready=1 in the abort cycle counts as transferred; index advances but no further term is shown.
- start while in RUN: ignored.
- start and abort together: abort wins.
- index does not wrap within a run, because the run ends at len-1 ≤ 2^IDX_WIDTH-2.
- count = 2^IDX_WIDTH-1 is legal.
- Async reset mid-run: immediate return to the reset values; the next run requires a new start.
- Seeds whose first sum already overflows (e.g. both at max) set overflow on the first transfer.

Test Plan:
- Defaults, seed0=0, seed1=1, count=10, out_ready=1; pulse start → out_valid rises 1 cycle later; values 0,1,1,2,3,5,8,13,21,34 on indices 0–9 in consecutive cycles; then done=1, out_valid=0, overflow=0.
- Backpressure: same run, drop out_ready for 3 cycles while showing index 4 → out_value=3 and out_index=4 held stable; the sequence resumes unchanged with no term lost or duplicated.
- Overflow stop (STOP_ON_OVF=1), seeds 0/1, count=100:
  - overflow goes to 1 on the transfer of index 23 (value 28657);
  - index 24 (value 46368) is emitted as the last term;
  - then done=1.
- Overflow wrap (STOP_ON_OVF=0), same stimulus → index 25 value 9489 (75025 mod 65536), overflow=1, run continues through index 99, then done.
- count=0 → done=1 one cycle after start, with no out_valid pulse. Seeds 5/7, count=3 → 5, 7, 12.
- Abort at index 6 → IDLE next cycle with out_valid=0 and done=0. A new start then runs from index 0. Asserting reset mid-run clears every output asynchronously, without waiting for a clock edge.
